// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event signals between scanner and its neighbours
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypress;
  logic       rdy;
  logic       keyheld;

  modport master (
    input  row,
    output col,
    output keypress,
    output rdy,
    output keyheld
  );

  modport slave (
    output row,
    input  col,
    input  keypress,
    input  rdy,
    input  keyheld
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with single-key debounce
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic             clk,
  input  logic             resetN,
  keypad_scanner_if.master kp_if
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  // Dwell-end sample is the first match, so PRESS accepts one count early.
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CNT - 2);

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  logic [3:0]    r_rs_meta;
  logic [3:0]    r_rs;
  state_t        r_state;
  logic [1:0]    r_cidx;
  logic [3:0]    r_col;
  logic [DW-1:0] r_dwell;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cand_row;
  logic [3:0]    r_keypress;
  logic          r_rdy;
  logic          r_keyheld;

  state_t        w_state_nxt;
  logic [1:0]    w_cidx_nxt;
  logic [DW-1:0] w_dwell_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_cand_nxt;
  logic [3:0]    w_keypress_nxt;
  logic          w_rdy_nxt;
  logic          w_keyheld_nxt;
  logic          w_rs_one_low;
  logic [1:0]    w_rs_row;
  logic [3:0]    w_cand_pattern;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  assign w_cand_pattern = ~(4'b0001 << r_cand_row);

  // Classify the synchronized rows: exactly one low line names a candidate row.
  always_comb begin
    w_rs_one_low = 1'b1;
    w_rs_row     = 2'd0;
    case (r_rs)
      4'b1110: w_rs_row = 2'd0;
      4'b1101: w_rs_row = 2'd1;
      4'b1011: w_rs_row = 2'd2;
      4'b0111: w_rs_row = 2'd3;
      default: w_rs_one_low = 1'b0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous row inputs; idles at all-released.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rs_meta <= 4'b1111;
      r_rs      <= 4'b1111;
    end else begin
      r_rs_meta <= kp_if.row;
      r_rs      <= r_rs_meta;
    end
  end

  // Scan / press-debounce / release-debounce next-state and output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cidx_nxt     = r_cidx;
    w_dwell_nxt    = r_dwell;
    w_cnt_nxt      = r_cnt;
    w_cand_nxt     = r_cand_row;
    w_keypress_nxt = r_keypress;
    w_rdy_nxt      = 1'b0;
    w_keyheld_nxt  = r_keyheld;
    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (w_rs_one_low) begin
            w_cand_nxt  = w_rs_row;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PRESS;
          end else begin
            w_cidx_nxt = r_cidx + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      ST_PRESS: begin
        if (r_rs == w_cand_pattern) begin
          if (r_cnt == CNT_ACCEPT) begin
            w_keypress_nxt = key_code(r_cand_row, r_cidx);
            w_rdy_nxt      = 1'b1;
            w_keyheld_nxt  = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = ST_HELD;
          end else if (r_cnt != CNT_LAST) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt   = '0;
          w_cidx_nxt  = r_cidx + 2'd1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_HELD: begin
        // Only a full release counts; any low row (including a second key) restarts the wait.
        if (r_rs == 4'b1111) begin
          if (r_cnt == CNT_LAST) begin
            w_keyheld_nxt = 1'b0;
            w_cnt_nxt     = '0;
            w_cidx_nxt    = r_cidx + 2'd1;
            w_state_nxt   = ST_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // State and output registers; col is decoded from the next index so it is a clean flop output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_SCAN;
      r_cidx     <= 2'd0;
      r_col      <= 4'b1110;
      r_dwell    <= '0;
      r_cnt      <= '0;
      r_cand_row <= 2'd0;
      r_keypress <= 4'h0;
      r_rdy      <= 1'b0;
      r_keyheld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cidx     <= w_cidx_nxt;
      r_col      <= ~(4'b0001 << w_cidx_nxt);
      r_dwell    <= w_dwell_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cand_row <= w_cand_nxt;
      r_keypress <= w_keypress_nxt;
      r_rdy      <= w_rdy_nxt;
      r_keyheld  <= w_keyheld_nxt;
    end
  end

  assign kp_if.col      = r_col;
  assign kp_if.keypress = r_keypress;
  assign kp_if.rdy      = r_rdy;
  assign kp_if.keyheld  = r_keyheld;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] pressed;
  logic        use_rand;
  logic [3:0]  rand_row;
  logic [3:0]  model_row;

  int n_checks   = 0;
  int n_fail     = 0;
  int rdy_count  = 0;
  int width_viol = 0;
  int kp_viol    = 0;
  logic       prev_rdy = 1'b0;
  logic [3:0] prev_kp  = 4'h0;

  always #5 clk = ~clk;

  keypad_scanner_if kp_if();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .kp_if  (kp_if)
  );

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    model_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp_if.col[c]) model_row[r] = 1'b0;
      end
    end
  end

  assign kp_if.row = use_rand ? rand_row : model_row;

  // Pulse monitor: counts rdy pulses, flags wide pulses and keypress changes without rdy.
  always @(negedge clk) begin
    if (!resetN) begin
      prev_rdy <= 1'b0;
      prev_kp  <= kp_if.keypress;
    end else begin
      if (kp_if.rdy) rdy_count <= rdy_count + 1;
      if (kp_if.rdy && prev_rdy) width_viol <= width_viol + 1;
      if ((kp_if.keypress !== prev_kp) && !kp_if.rdy) kp_viol <= kp_viol + 1;
      prev_rdy <= kp_if.rdy;
      prev_kp  <= kp_if.keypress;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy(input int max_cycles, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(posedge clk);
      #1;
      if (kp_if.rdy) found = 1'b1;
    end
  endtask

  task automatic wait_kh_low(input int max_cycles, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(posedge clk);
      #1;
      if (!kp_if.keyheld) found = 1'b1;
    end
  endtask

  function automatic int kidx(input int r, input int c);
    return r * 4 + c;
  endfunction

  initial begin
    logic       found;
    logic       seen;
    int         base;
    logic [3:0] exp_cols [4];
    logic [3:0] seq_code [4];
    int         seq_col  [4];

    exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq_code = '{4'd8, 4'd8, 4'd7, 4'd9};
    seq_col  = '{1, 1, 0, 2};

    pressed  = '0;
    use_rand = 1'b1;
    rand_row = 4'hF;
    resetN   = 1'b0;

    // Reset with random row activity.
    repeat (6) begin
      @(posedge clk);
      #1;
      rand_row = 4'($urandom_range(0, 15));
    end
    check_eq("rst_col", kp_if.col, 4'b1110);
    check_eq("rst_rdy", kp_if.rdy, 1'b0);
    check_eq("rst_keypress", kp_if.keypress, 4'h0);
    check_eq("rst_keyheld", kp_if.keyheld, 1'b0);
    resetN   = 1'b1;
    use_rand = 1'b0;
    tick(3);
    check_eq("col_dwell", kp_if.col, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      tick((k == 0) ? 1 : 4);
      check_eq("col_step", kp_if.col, exp_cols[k]);
    end

    // Clean press of key 9, held then released.
    base = rdy_count;
    pressed[kidx(2, 2)] = 1'b1;
    wait_rdy(200, found);
    check_eq("k9_rdy_seen", found, 1'b1);
    check_eq("k9_keypress", kp_if.keypress, 4'd9);
    check_eq("k9_keyheld", kp_if.keyheld, 1'b1);
    check_eq("k9_col_frozen", kp_if.col, 4'b1011);
    tick(30);
    check_eq("k9_hold_keyheld", kp_if.keyheld, 1'b1);
    check_eq("k9_hold_col", kp_if.col, 4'b1011);
    pressed = '0;
    tick(9);
    check_eq("k9_kh_before_fall", kp_if.keyheld, 1'b1);
    tick(1);
    check_eq("k9_kh_fall", kp_if.keyheld, 1'b0);
    check_eq("k9_resume_col", kp_if.col, 4'b0111);
    check_eq("k9_one_pulse", rdy_count - base, 1);

    // Bouncing key 8, then stable.
    base = rdy_count;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[kidx(2, 1)] = ~pressed[kidx(2, 1)];
      tick(1);
    end
    check_eq("bounce_no_rdy", rdy_count - base, 0);
    pressed[kidx(2, 1)] = 1'b1;
    wait_rdy(200, found);
    check_eq("k8_rdy_seen", found, 1'b1);
    check_eq("k8_keypress", kp_if.keypress, 4'd8);
    pressed = '0;
    wait_kh_low(100, found);
    check_eq("k8_release", found, 1'b1);
    tick(4);

    // Keys 1 and 4 share column 0: ambiguous, must be skipped.
    base = rdy_count;
    seen = 1'b0;
    pressed[kidx(0, 0)] = 1'b1;
    pressed[kidx(1, 0)] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (kp_if.col == 4'b0111) seen = 1'b1;
    end
    check_eq("dual_scan_continues", seen, 1'b1);
    check_eq("dual_no_rdy", rdy_count - base, 0);
    pressed = '0;
    tick(4);

    // Key 7 held, key 0 added during HELD: no rollover.
    base = rdy_count;
    pressed[kidx(2, 0)] = 1'b1;
    wait_rdy(200, found);
    check_eq("k7_rdy_seen", found, 1'b1);
    check_eq("k7_keypress", kp_if.keypress, 4'd7);
    tick(2);
    pressed[kidx(3, 1)] = 1'b1;
    tick(40);
    check_eq("k7k0_keyheld", kp_if.keyheld, 1'b1);
    check_eq("k7k0_keypress", kp_if.keypress, 4'd7);
    check_eq("k7k0_one_pulse", rdy_count - base, 1);
    pressed = '0;
    tick(60);
    check_eq("k7k0_after_release", rdy_count - base, 1);
    check_eq("k7k0_kh_low", kp_if.keyheld, 1'b0);

    // Sequence 8, 8, 7, 9 with full release between presses.
    base = rdy_count;
    for (int k = 0; k < 4; k++) begin
      pressed[kidx(2, seq_col[k])] = 1'b1;
      wait_rdy(200, found);
      check_eq("seq_rdy_seen", found, 1'b1);
      check_eq("seq_keypress", kp_if.keypress, seq_code[k]);
      tick(20);
      pressed = '0;
      wait_kh_low(100, found);
      check_eq("seq_release", found, 1'b1);
      tick(3);
    end
    check_eq("seq_pulse_count", rdy_count - base, 4);

    // Reset three cycles into HELD after key 9, then restart with key 1 already down.
    pressed[kidx(2, 2)] = 1'b1;
    wait_rdy(200, found);
    check_eq("rst9_rdy_seen", found, 1'b1);
    tick(3);
    resetN = 1'b0;
    #1;
    check_eq("rst9_col", kp_if.col, 4'b1110);
    check_eq("rst9_keypress", kp_if.keypress, 4'h0);
    check_eq("rst9_rdy", kp_if.rdy, 1'b0);
    check_eq("rst9_keyheld", kp_if.keyheld, 1'b0);
    pressed = '0;
    tick(3);
    base = rdy_count;
    pressed[kidx(0, 0)] = 1'b1;
    resetN = 1'b1;
    tick(10);
    check_eq("restart_rdy_early", kp_if.rdy, 1'b0);
    tick(1);
    check_eq("restart_rdy", kp_if.rdy, 1'b1);
    check_eq("restart_keypress", kp_if.keypress, 4'd1);
    tick(1);
    check_eq("restart_rdy_width", kp_if.rdy, 1'b0);
    check_eq("restart_one_pulse", rdy_count - base, 1);
    pressed = '0;
    tick(20);

    check_eq("rdy_width_violations", width_viol, 0);
    check_eq("keypress_change_violations", kp_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces one key at a time, and presents each confirmed press to the lock controller as a 4-bit code with a one-cycle `rdy` strobe. It is the stage directly upstream of the lock controller, which consumes `keypress` and `rdy` and reacts to codes 7, 8 and 9. One press yields exactly one `rdy` pulse, regardless of hold time or contact bounce.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before advancing; minimum 4.
- `DEBOUNCE_CNT`, default 20000: consecutive stable synchronized samples needed to accept a press or a release; minimum 2.
- `clk`  in  1  system clock.
- `resetN`  in  1  reset, asynchronous, active-low; clock `clk`.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `keypress`  out  4  code of the last accepted key; held until the next accepted key.
- `rdy`  out  1  one-cycle pulse; `keypress` is valid in the same cycle.
- `keyheld`  out  1  high from acceptance until release is confirmed.

## Operation
- Key map, as row r / col c to code:
  - r0: 1, 2, 3, A=10
  - r1: 4, 5, 6, B=11
  - r2: 7, 8, 9, C=12
  - r3: *=14, 0=0, #=15, D=13
- `row` passes through a 2-flop synchronizer (`rs`). All decisions use `rs`.
- State SCAN:
  - Drives column `cidx`. A dwell counter runs 0..SCAN_DIV-1.
  - At dwell = SCAN_DIV-1, `rs` is sampled:
    - Exactly one bit low: latch `cand_row` and `cidx`, clear the debounce counter, go to PRESS.
    - Otherwise (all high, or two or more low): `cidx` advances, wrapping 3 to 0, and the dwell counter restarts.
- State PRESS:
  - `col` stays frozen.
  - Each cycle `rs` equals the one-hot-low pattern of `cand_row`, the counter increments.
  - Any other `rs` value returns to SCAN at the next column with no output.
  - When the counter reaches DEBOUNCE_CNT-1 with a matching sample:
    - Load `keypress` from the map.
    - Pulse `rdy`.
    - Set `keyheld`.
    - Go to HELD.
- State HELD:
  - `col` stays frozen.
  - The counter increments while `rs`==4'b1111 and clears on any low bit.
  - At DEBOUNCE_CNT-1 it clears `keyheld` and goes to SCAN, advancing to the next column.
  - A second key pressed during HELD is ignored; no rollover.
- Counters are sized with `$clog2` of their parameter and saturate; they never wrap.
- Reset values: `col`=4'b1110 (`cidx`=0), `keypress`=4'h0, `rdy`=0, `keyheld`=0, state SCAN, all counters 0, synchronizer flops 4'b1111.
- Reset mid-PRESS or mid-HELD returns to these values immediately, with no `rdy` pulse.

## Timing
- Synchronizer latency: 2 cycles from a `row` edge to `rs`.
- `rdy` asserts in the cycle after the DEBOUNCE_CNT-th consecutive matching `rs` sample; the first sample is the one taken at the end of dwell.
- `rdy` is high for exactly 1 cycle.
- `keypress` updates on the same clock edge that raises `rdy`. It never changes on any other edge after reset.
- Minimum spacing between two `rdy` pulses: 2*DEBOUNCE_CNT + 1 cycles.
- Worst-case detection delay for a stable press: 4*SCAN_DIV + 2 cycles before PRESS is entered.
- `col` changes only on dwell wrap or on a PRESS/HELD exit.
- `col` is registered and glitch-free.

## Test plan
Benches run with SCAN_DIV=4 and DEBOUNCE_CNT=8.
- Reset: hold `resetN`=0 with `row` random, then release. Required: `col`=1110, `rdy`=0, `keypress`=0, `keyheld`=0; `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Clean press of key 9 (row2, col2), held 40 cycles then released. Required: exactly one `rdy` pulse with `keypress`=9; `keyheld` falls 8 cycles after `rs` returns to 1111; scanning resumes at `col`=0111.
- Bounce on key 8: toggle the row2 line every 3 cycles for 20 cycles, then hold stable. Required: no `rdy` during the bounce; one `rdy` with `keypress`=8 after 8 stable samples.
- Two keys in the same column (keys 1 and 4): required no `rdy` and scanning continues. Also press key 7, then add key 0 while in HELD: required only one `rdy` with `keypress`=7, and no pulse for 0 until 7 and 0 are both released.
- Sequence 8, 8, 7, 9 with full release between presses: required four `rdy` pulses carrying 8, 8, 7, 9 in order, each pulse 1 cycle wide, and `keypress` stable between pulses.
- Assert `resetN` low 3 cycles into HELD after key 9: required immediate return to reset values, no extra `rdy`, and a normal restart of scanning once reset is released.
